// File: rtl/dac_stream_seq_pkg.sv
// Shared types and constants for the DAC stream sequencer: FSM states, SPI peripheral
// register offsets and the DAC command word layout.
package dac_stream_seq_pkg;

  typedef enum logic [2:0] {
    ST_CFG0   = 3'd0,
    ST_CFG1   = 3'd1,
    ST_CFG2   = 3'd2,
    ST_IDLE   = 3'd3,
    ST_WR_A   = 3'd4,
    ST_POLL_A = 3'd5,
    ST_WR_B   = 3'd6,
    ST_POLL_B = 3'd7
  } seq_state_t;

  localparam logic [3:0] REG_DATA = 4'h0;
  localparam logic [3:0] REG_STAT = 4'h4;
  localparam logic [3:0] REG_CYC  = 4'h8;
  localparam logic [3:0] REG_DIV  = 4'hC;

  localparam logic [3:0] DAC_CMD       = 4'h3;
  localparam int         STAT_DONE_BIT = 31;

  // {8'h00, command, channel, code}: channel 0 = A, 1 = B.
  function automatic logic [31:0] dac_word(input logic ch_b, input logic [15:0] code);
    return {8'h00, DAC_CMD, {3'b000, ch_b}, code};
  endfunction

endpackage

// File: rtl/simple_bus_txn.sv
// Single-transaction issuer for the simple bus: turns a one-cycle start into a one-cycle
// wr/rd pulse, holds address/data until the matching Done, and reports completion.
module simple_bus_txn #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              is_rd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr_o,
  output logic              rd_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              wr_done_i,
  input  logic              rd_done_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              wr_q, rd_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              pending_q, pend_rd_q;

  // Done counts only while a transaction of the matching kind is outstanding.
  assign done_o  = pending_q & (pend_rd_q ? rd_done_i : wr_done_i);
  assign rdata_o = rd_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      pending_q <= 1'b0;
      pend_rd_q <= 1'b0;
    end else begin
      wr_q <= start_i & ~is_rd_i;
      rd_q <= start_i & is_rd_i;
      if (start_i) begin
        pending_q <= 1'b1;
        pend_rd_q <= is_rd_i;
        if (is_rd_i) begin
          rd_addr_q <= addr_i;
        end else begin
          wr_addr_q <= addr_i;
          wr_data_q <= data_i;
        end
      end else if (done_o) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign wr_o      = wr_q;
  assign rd_o      = rd_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_addr_o = rd_addr_q;

endmodule

// File: rtl/dac_stream_sequencer.sv
// Programs the SPI peripheral after reset, then streams A/B DAC sample pairs over the simple bus.
// Optional POLL_TIMEOUT_EN: bounds status polling per word and flags err on expiry.
module dac_stream_sequencer
  import dac_stream_seq_pkg::*;
#(
  parameter int          ADDR_W     = 4,
  parameter int          DATA_W     = 32,
  parameter logic [23:0] INIT_WORD  = 24'h508000,
  parameter logic [31:0] CYCLE_MAX  = 32'h18,
  parameter logic [31:0] SAMPLE_DIV = 32'h258,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_data_a,
  input  logic [15:0]       s_data_b,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              wr,
  input  logic              wrDone,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              rd,
  input  logic [DATA_W-1:0] rdData,
  input  logic              rdDone,
  output logic              cfg_done,
  output logic              busy,
  output logic              err,
  output logic [2:0]        dbg_state_o
);

  seq_state_t state_q, state_d;
  logic       issued_q, issued_d;
  logic       busy_q, busy_d;
  logic       cfg_done_q, cfg_done_d;
  logic [15:0] code_a_q, code_a_d, code_b_q, code_b_d;

  logic              txn_start, txn_is_rd, txn_done;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_data, txn_rdata;
  logic              in_poll, ready_c;
  logic              unused_rdata;

`ifdef POLL_TIMEOUT_EN
  logic        err_q, err_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
`endif

  assign in_poll      = (state_q == ST_POLL_A) || (state_q == ST_POLL_B);
  assign unused_rdata = ^txn_rdata;

  // Sample handshake: a pair transfers on a clock edge where s_valid & s_ready; s_ready is
  // only offered in IDLE, and the source must hold s_valid/data until it sees s_ready.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    busy_d     = busy_q;
    cfg_done_d = cfg_done_q;
    code_a_d   = code_a_q;
    code_b_d   = code_b_q;
    txn_start  = 1'b0;
    txn_is_rd  = 1'b0;
    txn_addr   = ADDR_W'(REG_DATA);
    txn_data   = '0;
    ready_c    = 1'b0;
`ifdef POLL_TIMEOUT_EN
    err_d      = err_q;
    poll_cnt_d = poll_cnt_q;
`endif

    case (state_q)
      ST_CFG0: begin
        txn_data = DATA_W'(INIT_WORD);
        if (txn_done) state_d = ST_CFG1;
      end
      ST_CFG1: begin
        txn_addr = ADDR_W'(REG_CYC);
        txn_data = DATA_W'(CYCLE_MAX);
        if (txn_done) state_d = ST_CFG2;
      end
      ST_CFG2: begin
        txn_addr = ADDR_W'(REG_DIV);
        txn_data = DATA_W'(SAMPLE_DIV);
        if (txn_done) begin
          state_d    = ST_IDLE;
          cfg_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        ready_c = enable & cfg_done_q & ~busy_q;
        if (ready_c && s_valid) begin
          code_a_d = s_data_a;
          code_b_d = s_data_b;
          busy_d   = 1'b1;
          state_d  = ST_WR_A;
        end
      end
      ST_WR_A: begin
        txn_data = DATA_W'(dac_word(1'b0, code_a_q));
        if (txn_done) state_d = ST_POLL_A;
      end
      ST_WR_B: begin
        txn_data = DATA_W'(dac_word(1'b1, code_b_q));
        if (txn_done) state_d = ST_POLL_B;
      end
      ST_POLL_A, ST_POLL_B: begin
        txn_is_rd = 1'b1;
        txn_addr  = ADDR_W'(REG_STAT);
      end
      default: state_d = ST_CFG0;
    endcase

    // A not-done status read is reissued in the same cycle its rdDone is seen.
    if (in_poll && txn_done) begin
      if (txn_rdata[STAT_DONE_BIT]) begin
        if (state_q == ST_POLL_A) begin
          state_d = ST_WR_B;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end else begin
`ifdef POLL_TIMEOUT_EN
        if (poll_cnt_q == 16'(POLL_LIMIT - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          poll_cnt_d = poll_cnt_q + 16'd1;
          txn_start  = 1'b1;
        end
`else
        txn_start = 1'b1;
`endif
      end
    end

    if (state_d != state_q) begin
      issued_d = 1'b0;
`ifdef POLL_TIMEOUT_EN
      poll_cnt_d = '0;
`endif
    end else if (state_q != ST_IDLE && !issued_q) begin
      txn_start = 1'b1;
      issued_d  = 1'b1;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= ST_CFG0;
      issued_q   <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      code_a_q   <= '0;
      code_b_q   <= '0;
`ifdef POLL_TIMEOUT_EN
      err_q      <= 1'b0;
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      code_a_q   <= code_a_d;
      code_b_q   <= code_b_d;
`ifdef POLL_TIMEOUT_EN
      err_q      <= err_d;
      poll_cnt_q <= poll_cnt_d;
`endif
    end
  end

  simple_bus_txn #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_txn (
    .clk_i     (M_AXI_ACLK),
    .rst_ni    (M_AXI_ARESETN),
    .start_i   (txn_start),
    .is_rd_i   (txn_is_rd),
    .addr_i    (txn_addr),
    .data_i    (txn_data),
    .wr_o      (wr),
    .rd_o      (rd),
    .wr_addr_o (wrAddr),
    .wr_data_o (wrData),
    .rd_addr_o (rdAddr),
    .wr_done_i (wrDone),
    .rd_done_i (rdDone),
    .rd_data_i (rdData),
    .done_o    (txn_done),
    .rdata_o   (txn_rdata)
  );

  assign s_ready     = ready_c;
  assign cfg_done    = cfg_done_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;
`ifdef POLL_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dac_stream_sequencer.sv
// Bench for dac_stream_sequencer: bus manager model, expected-transaction scoreboard and
// per-cycle checks of cfg_done/busy/s_ready/err derived from the sequencing rules.
`timescale 1ns/1ps
module tb_dac_stream_sequencer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int EW     = 38;  // {last, is_rd, addr[3:0], data[31:0]}

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable, s_valid, s_ready;
  logic [15:0]       s_data_a, s_data_b;
  logic [ADDR_W-1:0] wrAddr, rdAddr;
  logic [DATA_W-1:0] wrData, rdData;
  logic              wr, rd, wrDone, rdDone;
  logic              cfg_done, busy, err;
  logic [2:0]        dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dac_stream_sequencer #(.POLL_LIMIT(8)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .enable        (enable),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data_a      (s_data_a),
    .s_data_b      (s_data_b),
    .wrAddr        (wrAddr),
    .wrData        (wrData),
    .wr            (wr),
    .wrDone        (wrDone),
    .rdAddr        (rdAddr),
    .rd            (rd),
    .rdData        (rdData),
    .rdDone        (rdDone),
    .cfg_done      (cfg_done),
    .busy          (busy),
    .err           (err),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic          stat_q[$];
  logic [EW-1:0] cur;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cfg_cnt = 0;
  int            n_wr = 0, n_rd = 0;
  logic          m_busy = 1'b0, m_err = 1'b0, outstanding = 1'b0;
  logic          never_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic last, input logic is_rd,
                                       input logic [3:0] addr, input logic [31:0] data);
    return {last, is_rd, addr, data};
  endfunction

  function automatic logic [31:0] dac_w(input int ch, input logic [15:0] code);
    return {8'h00, 4'h3, 4'(ch), code};
  endfunction

  task automatic expect_init();
    exp_q.push_back(mk(1'b0, 1'b0, 4'h0, 32'h0050_8000));
    exp_q.push_back(mk(1'b0, 1'b0, 4'h8, 32'h0000_0018));
    exp_q.push_back(mk(1'b0, 1'b0, 4'hC, 32'h0000_0258));
  endtask

  // Pair model: word A, na status reads (last one done), word B, nb reads (last one done).
  task automatic expect_pair(input logic [15:0] a, input logic [15:0] b, input int na, input int nb);
    exp_q.push_back(mk(1'b0, 1'b0, 4'h0, dac_w(0, a)));
    for (int i = 0; i < na; i++) begin
      exp_q.push_back(mk(1'b0, 1'b1, 4'h4, 32'h0));
      stat_q.push_back(i == na - 1);
    end
    exp_q.push_back(mk(1'b0, 1'b0, 4'h0, dac_w(1, b)));
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(mk(i == nb - 1, 1'b1, 4'h4, 32'h0));
      stat_q.push_back(i == nb - 1);
    end
  endtask

  // ---------------- bus manager model: Done 3 cycles after each request ----------------
  initial begin : manager
    int   cnt;
    logic m_rd;
    logic sbit;
    wrDone = 1'b0; rdDone = 1'b0; rdData = '0; cnt = 0; m_rd = 1'b0;
    forever begin
      @(negedge clk);
      wrDone = 1'b0;
      rdDone = 1'b0;
      if (!rst_n) begin
        cnt = 0;
        continue;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (m_rd) begin
            if (never_done)             sbit = 1'b0;
            else if (stat_q.size() > 0) sbit = stat_q.pop_front();
            else                        sbit = 1'b1;
            rdData = {sbit, 31'($urandom)};
            rdDone = 1'b1;
          end else begin
            wrDone = 1'b1;
          end
        end
      end
      if (wr || rd) begin
        cnt  = 3;
        m_rd = rd;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic          hs;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      hs = s_valid & s_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cfg_cnt = 0; m_busy = 1'b0; m_err = 1'b0; outstanding = 1'b0;
        continue;
      end
      if (outstanding && (cur[36] ? rdDone : wrDone)) begin
        outstanding = 1'b0;
        if (!cur[36] && cfg_cnt < 3) cfg_cnt++;
        if (cur[36] && cur[37]) begin
          m_busy = 1'b0;
          if (!rdData[31]) m_err = 1'b1;
        end
      end
      if (hs) m_busy = 1'b1;
      if (wr || rd) begin
        chk("one_txn_outstanding", outstanding, 0);
        chk("wr_rd_exclusive", wr & rd, 0);
        chk("txn_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("txn_kind_is_rd", rd, e[36]);
          chk("txn_addr", rd ? rdAddr : wrAddr, e[35:32]);
          if (!e[36]) chk("txn_wdata", wrData, e[31:0]);
          cur = e;
        end
        outstanding = 1'b1;
        if (wr) n_wr++;
        else    n_rd++;
      end else if (outstanding) begin
        chk("hold_addr", cur[36] ? rdAddr : wrAddr, cur[35:32]);
        if (!cur[36]) chk("hold_wdata", wrData, cur[31:0]);
      end
      chk("cfg_done", cfg_done, cfg_cnt == 3);
      chk("busy", busy, m_busy);
      chk("s_ready", s_ready, enable & (cfg_cnt == 3) & ~m_busy);
      chk("err", err, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int budget);
    logic got;
    got = 1'b0;
    @(negedge clk);
    s_valid  = 1'b1;
    s_data_a = a;
    s_data_b = b;
    for (int i = 0; i < budget; i++) begin
      #3;
      if (s_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("handshake_in_budget", got, 1);
  endtask

  task automatic wait_drain(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !outstanding && !m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_in_budget", ok, 1);
    @(negedge clk);
  endtask

  task automatic wait_count_up(input int base, input logic use_rd, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if ((use_rd ? n_rd : n_wr) > base) begin
        ok = 1'b1;
        break;
      end
    end
    chk("txn_seen_in_budget", ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_rd"}, rd, 0);
    chk({tag, "_wrAddr"}, wrAddr, 0);
    chk({tag, "_wrData"}, wrData, 0);
    chk({tag, "_rdAddr"}, rdAddr, 0);
    chk({tag, "_cfg_done"}, cfg_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int wr0, rd0;
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data_a = '0; s_data_b = '0;

    // Reset state and init sequence.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    expect_init();
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_drain(300);
    chk("init_cfg_done", cfg_done, 1);
    chk("init_write_count", n_wr, 3);
    chk("init_no_reads", n_rd, 0);

    // First pair, literal bus words, status done on the third A read.
    wr0 = n_wr; rd0 = n_rd;
    exp_q.push_back(mk(1'b0, 1'b0, 4'h0, 32'h0030_1234));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 1'b1, 4'h4, 32'h0));
    stat_q.push_back(1'b0); stat_q.push_back(1'b0); stat_q.push_back(1'b1);
    exp_q.push_back(mk(1'b0, 1'b0, 4'h0, 32'h0031_ABCD));
    exp_q.push_back(mk(1'b1, 1'b1, 4'h4, 32'h0));
    stat_q.push_back(1'b1);
    send_pair(16'h1234, 16'hABCD, 50);
    wait_drain(300);
    chk("pair1_busy_low", busy, 0);
    chk("pair1_ready_again", s_ready, 1);
    chk("pair1_writes", n_wr - wr0, 2);
    chk("pair1_reads", n_rd - rd0, 4);

    // Second pair presented while the first is in flight.
    rd0 = n_rd;
    expect_pair(16'h0F0F, 16'h00FF, 2, 3);
    expect_pair(16'hC3C3, 16'h3C3C, 1, 2);
    send_pair(16'h0F0F, 16'h00FF, 50);
    send_pair(16'hC3C3, 16'h3C3C, 400);
    chk("pair2_waited_for_pair1", (n_rd - rd0) >= 5, 1);
    wait_drain(400);

    // enable dropped during POLL_A: pair completes, then no acceptance.
    rd0 = n_rd;
    expect_pair(16'h0001, 16'hFFFF, 4, 2);
    send_pair(16'h0001, 16'hFFFF, 50);
    wait_count_up(rd0, 1'b1, 100);
    @(negedge clk);
    enable = 1'b0;
    wait_drain(400);
    chk("disable_pair_done_busy", busy, 0);
    chk("disable_pair_reads", n_rd - rd0, 6);
    wr0 = n_wr;
    s_valid = 1'b1; s_data_a = 16'h8000; s_data_b = 16'h7FFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #3;
      chk("ready_low_while_disabled", s_ready, 0);
    end
    chk("no_writes_while_disabled", n_wr - wr0, 0);
    @(negedge clk);
    s_valid = 1'b0;
    enable  = 1'b1;
    expect_pair(16'h8000, 16'h7FFF, 1, 1);
    send_pair(16'h8000, 16'h7FFF, 50);
    wait_drain(300);

    // Reset while the channel-A write awaits wrDone.
    wr0 = n_wr;
    expect_pair(16'h5555, 16'hAAAA, 1, 1);
    send_pair(16'h5555, 16'hAAAA, 50);
    wait_count_up(wr0, 1'b0, 50);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midtxn_reset");
    exp_q.delete();
    stat_q.delete();
    repeat (3) @(negedge clk);
    expect_init();
    rst_n = 1'b1;
    wait_drain(300);
    chk("reinit_cfg_done", cfg_done, 1);
    expect_pair(16'h2468, 16'h1357, 2, 1);
    send_pair(16'h2468, 16'h1357, 50);
    wait_drain(300);

`ifdef POLL_TIMEOUT_EN
    // Status never done: exactly POLL_LIMIT (8) reads, then err and pair abandoned.
    rd0 = n_rd;
    never_done = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 4'h0, 32'h0030_0BAD));
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(i == 7, 1'b1, 4'h4, 32'h0));
    send_pair(16'h0BAD, 16'hBEEF, 50);
    wait_drain(400);
    repeat (5) @(negedge clk);
    chk("timeout_reads", n_rd - rd0, 8);
    chk("timeout_err", err, 1);
    chk("timeout_busy", busy, 0);
    never_done = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_err", err, m_err);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
